// File: rtl/vme_cmd_executor.sv
// vme_cmd_executor: decodes one VME command word per start pulse, runs a
// single-word cycle on the internal register bus and returns the response
// (read data, write echo or error code) with a one-cycle vme_dat_wr strobe.
module vme_cmd_executor #(
  parameter logic [7:0]  TAG      = 8'hA8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic [31:0] vme_dat_reg_out,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic        bus_strobe,
  output logic        bus_write,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic [15:0] cmd_count,
  output logic [7:0]  err_count,
  output logic        overrun
);

  // Last WAIT cycle count value before the timeout fires (counter starts at 0).
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] dat_out_q, dat_out_d;
  logic [15:0] cmd_count_q, cmd_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        overrun_q, overrun_d;

  logic cmd_legal;
  logic timeout_hit;

  // Upper command/data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

  assign cmd_legal   = (vme_cmd_reg[23:16] == TAG) && (vme_cmd_reg[25] ^ vme_cmd_reg[24]);
  assign timeout_hit = (cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: illegal commands skip the bus cycle entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = cmd_legal ? S_WAIT : S_DONE;
      S_WAIT:  if (bus_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs are decoded from state so a reset drops bus_strobe at once.
  always_comb begin
    vme_cmd_rd = (state_q == S_IDLE);
    bus_strobe = (state_q == S_WAIT);
    vme_dat_wr = (state_q == S_DONE);
  end

  // Datapath: latch command, count WAIT cycles, build the response and the
  // statistics on the transition into DONE (ack takes priority over timeout).
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    dat_out_d   = dat_out_q;
    cmd_count_d = cmd_count_q;
    err_count_d = err_count_q;
    overrun_d   = overrun_q;

    if (start && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = vme_cmd_reg[15:0];
          wdata_d = vme_dat_reg_in[15:0];
          write_d = vme_cmd_reg[24];
          cnt_d   = 16'd0;
          if (!cmd_legal) begin
            dat_out_d   = {1'b0, 1'b1, 14'd0, ERR_DATA};
            cmd_count_d = cmd_count_q + 16'd1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          dat_out_d   = {16'd0, (write_q ? wdata_q : bus_rdata)};
          cmd_count_d = cmd_count_q + 16'd1;
        end else if (timeout_hit) begin
          dat_out_d   = {1'b1, 15'd0, ERR_DATA};
          cmd_count_d = cmd_count_q + 16'd1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= 16'd0;
      wdata_q     <= 16'd0;
      write_q     <= 1'b0;
      cnt_q       <= 16'd0;
      dat_out_q   <= 32'd0;
      cmd_count_q <= 16'd0;
      err_count_q <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      dat_out_q   <= dat_out_d;
      cmd_count_q <= cmd_count_d;
      err_count_q <= err_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign vme_dat_reg_out = dat_out_q;
  assign bus_addr        = addr_q;
  assign bus_wdata       = wdata_q;
  assign bus_write       = write_q;
  assign cmd_count       = cmd_count_q;
  assign err_count       = err_count_q;
  assign overrun         = overrun_q;

endmodule

// File: doc/vme_cmd_executor.md
Name: vme_cmd_executor

Overview:
Synthesizable responder for the VME command-register interface that the simulation file handler drives. It accepts one 32-bit command word plus write data per start pulse, decodes it, and runs a single-word cycle on the internal register bus. It returns read data or a write echo on vme_dat_reg_out with a one-cycle vme_dat_wr strobe, and raises vme_cmd_rd when ready for the next command. It sits between the VME front end (or the file-driven bench) and the ODMB internal register map.

Parameters:
TAG, 8'hA8, required value of command bits [23:16].
TIMEOUT, 255, maximum cycles spent in WAIT before a timeout is declared; legal range 1..65535.
ERR_DATA, 16'hDEAD, value placed in vme_dat_reg_out[15:0] on a timeout or an illegal command.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  command valid; sampled only in IDLE.
vme_cmd_reg  in  32  command word: [15:0] register address, [23:16] tag, [24] write, [25] read, [31:26] ignored.
vme_dat_reg_in  in  32  write data; [15:0] used, [31:16] ignored.
vme_dat_reg_out  out  32  response: [31] timeout, [30] illegal command, [29:16] zero, [15:0] data.
vme_cmd_rd  out  1  high while in IDLE, meaning ready for a command.
vme_dat_wr  out  1  one-cycle pulse: vme_dat_reg_out is valid.
bus_strobe  out  1  register-bus cycle request.
bus_write  out  1  1 = write cycle, 0 = read cycle; held stable while bus_strobe is high.
bus_addr  out  16  register address.
bus_wdata  out  16  write data.
bus_rdata  in  16  read data, valid when bus_ack is high.
bus_ack  in  1  cycle complete.
cmd_count  out  16  completed commands, including errored ones; wraps at 16'hFFFF to 0.
err_count  out  8  timeouts plus illegal commands; saturates at 8'hFF.
overrun  out  1  sticky flag: start was seen outside IDLE; cleared only by reset.

Behaviour:
- Reset (async assert, synchronous release): state = IDLE; vme_cmd_rd = 1; all other outputs 0, including vme_dat_reg_out, both counters and overrun.
- A reset asserted mid-cycle drops bus_strobe immediately. No vme_dat_wr is issued for the aborted command.
- States: IDLE, WAIT, DONE.
- IDLE:
  - vme_cmd_rd = 1.
  - On start = 1 at a rising edge, latch the address, write data and R/W bits.
  - Command is legal when [23:16] == TAG and exactly one of bits [25:24] is set.
  - Legal command: go to WAIT. bus_strobe, bus_write, bus_addr and bus_wdata are driven from the registered latch starting the next cycle.
  - Illegal command: go directly to DONE; no bus cycle is run.
- WAIT:
  - bus_strobe = 1 and vme_cmd_rd = 0; a cycle counter increments every clock.
  - bus_ack is sampled only in WAIT.
  - bus_ack = 1 at an edge: capture bus_rdata (read) or the latched write data (write) into data, drop bus_strobe, go to DONE.
  - Counter reaches TIMEOUT with no ack: data = ERR_DATA, bit 31 = 1, drop bus_strobe, go to DONE.
  - If ack and timeout occur on the same edge, the ack wins.
- DONE:
  - vme_dat_wr = 1 for exactly one cycle.
  - vme_dat_reg_out is updated on entry to DONE and held until the next DONE.
  - cmd_count increments; err_count increments (saturating) on a timeout or illegal command.
  - Next state is IDLE.
- Illegal command response: bit 30 = 1, [15:0] = ERR_DATA.
- Legal write response: [15:0] = echo of the write data.
- A bus_ack arriving in IDLE or DONE (late ack) is ignored and does not alter any output.
- start seen in WAIT or DONE is ignored and sets overrun.
- Minimum latency, with ack returned on the first WAIT cycle:
  - start sampled at edge N;
  - bus_strobe high N→N+1;
  - ack sampled at N+1;
  - vme_dat_wr high N+1→N+2;
  - vme_cmd_rd high again after N+2.
- Exactly one vme_dat_wr pulse per accepted start.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → vme_cmd_rd = 1; every other output is 0.
- Read: start with cmd 32'h02A8_1234; responder acks on the 3rd WAIT cycle with rdata 16'hBEEF → bus_addr = 16'h1234, bus_write = 0, bus_strobe high for 3 cycles, one vme_dat_wr pulse with vme_dat_reg_out = 32'h0000_BEEF, cmd_count = 1.
- Write: cmd 32'h01A8_0010, data 32'h0000_5A5A; immediate ack → bus_write = 1, bus_wdata = 16'h5A5A, vme_dat_reg_out = 32'h0000_5A5A, vme_dat_wr on cycle N+1.
- Illegal command, run once with cmd 32'h03A8_0001 (both bits set) and once with cmd 32'h0200_0001 (bad tag) → bus_strobe never asserts; vme_dat_reg_out = 32'h4000_DEAD each time; err_count increments each time.
- Timeout: TIMEOUT = 4, no ack → bus_strobe high for 4 cycles; vme_dat_reg_out = 32'h8000_DEAD; a late ack one cycle afterwards changes nothing. Then 300 consecutive timeouts → err_count = 8'hFF.
- Overrun and mid-cycle reset: pulse start during WAIT → overrun = 1 and the command is not executed. Assert rst_n = 0 mid-WAIT → bus_strobe falls without waiting for a clock, no vme_dat_wr, and the next command after release runs normally.
